// File: rtl/keypad_encoder.sv
// 4x4 active-low matrix keypad scanner with press/release debounce.
// Emits a one-shot {1, PREAMBLE, key} code for HOLD_CYCLES clocks per press.
module keypad_encoder #(
    parameter int unsigned COL_DWELL      = 4,
    parameter int unsigned DEBOUNCE_SCANS = 5,
    parameter int unsigned HOLD_CYCLES    = 8,
    parameter logic [2:0]  PREAMBLE       = 3'b101
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] row_n,
    output logic [3:0] col_n,
    output logic [7:0] code,
    output logic       busy
);

    localparam int unsigned DW = $clog2(COL_DWELL) + 1;
    localparam int unsigned MW = $clog2(DEBOUNCE_SCANS) + 1;
    localparam int unsigned HW = $clog2(HOLD_CYCLES) + 1;

    typedef enum logic [1:0] {
        ST_SCAN,
        ST_DEBOUNCE,
        ST_EMIT,
        ST_WAIT_RELEASE
    } state_e;

    state_e          state_q, state_d;
    logic [3:0]      sync1_q, rs_q;
    logic [DW-1:0]   dwell_q, dwell_d;
    logic [MW-1:0]   match_q, match_d;
    logic [MW-1:0]   rel_q, rel_d;
    logic [HW-1:0]   hold_q, hold_d;
    logic [3:0]      key_q, key_d;
    logic [3:0]      col_n_q, col_n_d;
    logic [7:0]      code_q, code_d;
    logic            busy_q, busy_d;

    logic            sample;
    logic            any_low;
    logic [1:0]      low_row;
    logic [1:0]      col_idx;
    logic [3:0]      col_rot;
    logic [MW-1:0]   match_inc, rel_inc;

    always_comb begin
        sample    = (dwell_q == DW'(COL_DWELL - 1));
        any_low   = (rs_q != 4'hF);
        col_rot   = {col_n_q[2:0], col_n_q[3]};
        match_inc = MW'(match_q + MW'(1));
        rel_inc   = MW'(rel_q + MW'(1));

        // Lowest-indexed low row wins
        if (!rs_q[0])      low_row = 2'd0;
        else if (!rs_q[1]) low_row = 2'd1;
        else if (!rs_q[2]) low_row = 2'd2;
        else               low_row = 2'd3;

        case (col_n_q)
            4'b1101: col_idx = 2'd1;
            4'b1011: col_idx = 2'd2;
            4'b0111: col_idx = 2'd3;
            default: col_idx = 2'd0;
        endcase
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d = state_q;
        dwell_d = sample ? '0 : DW'(dwell_q + DW'(1));
        match_d = match_q;
        rel_d   = rel_q;
        hold_d  = hold_q;
        key_d   = key_q;
        col_n_d = col_n_q;
        code_d  = code_q;

        case (state_q)
            ST_SCAN: begin
                code_d = 8'h00;
                if (sample) begin
                    if (!any_low) begin
                        col_n_d = col_rot;
                    end else begin
                        key_d   = {col_idx, low_row};
                        match_d = MW'(1);
                        state_d = ST_DEBOUNCE;
                    end
                end
            end
            ST_DEBOUNCE: begin
                if (sample) begin
                    if (any_low && (low_row == key_q[1:0])) begin
                        match_d = match_inc;
                        if (match_inc == MW'(DEBOUNCE_SCANS)) begin
                            state_d = ST_EMIT;
                            hold_d  = HW'(1);
                            code_d  = {1'b1, PREAMBLE, key_q};
                        end
                    end else begin
                        match_d = '0;
                        col_n_d = col_rot;
                        state_d = ST_SCAN;
                    end
                end
            end
            ST_EMIT: begin
                if (hold_q == HW'(HOLD_CYCLES)) begin
                    code_d  = 8'h00;
                    hold_d  = '0;
                    match_d = '0;
                    rel_d   = '0;
                    state_d = ST_WAIT_RELEASE;
                end else begin
                    hold_d = HW'(hold_q + HW'(1));
                end
            end
            ST_WAIT_RELEASE: begin
                code_d = 8'h00;
                if (sample) begin
                    if (rs_q[key_q[1:0]]) begin
                        if (rel_inc == MW'(DEBOUNCE_SCANS)) begin
                            rel_d   = '0;
                            col_n_d = col_rot;
                            state_d = ST_SCAN;
                        end else begin
                            rel_d = rel_inc;
                        end
                    end else begin
                        rel_d = '0;
                    end
                end
            end
            default: begin
                state_d = ST_SCAN;
                code_d  = 8'h00;
            end
        endcase

        busy_d = (state_d != ST_SCAN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_SCAN;
            sync1_q <= 4'hF;
            rs_q    <= 4'hF;
            dwell_q <= '0;
            match_q <= '0;
            rel_q   <= '0;
            hold_q  <= '0;
            key_q   <= '0;
            col_n_q <= 4'b1110;
            code_q  <= 8'h00;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sync1_q <= row_n;
            rs_q    <= sync1_q;
            dwell_q <= dwell_d;
            match_q <= match_d;
            rel_q   <= rel_d;
            hold_q  <= hold_d;
            key_q   <= key_d;
            col_n_q <= col_n_d;
            code_q  <= code_d;
            busy_q  <= busy_d;
        end
    end

    assign col_n = col_n_q;
    assign code  = code_q;
    assign busy  = busy_q;

endmodule
